// File: rtl/lcd_pkg.sv
// Shared constants, encodings and text helpers for the HD44780 refresh sequencer.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] DISP_OFF = 8'h08;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] HOME     = 8'h02;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;

  localparam logic [31:0]  CRC_TAG  = "CRC:";
  localparam logic [127:0] STAT_OK  = "STATUS: OK      ";
  localparam logic [127:0] STAT_ERR = "STATUS: ERROR   ";

  typedef enum logic [1:0] {
    OP_CRC    = 2'b00,
    OP_STATUS = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_OFF    = 2'b11
  } usr_op_t;

  typedef enum logic [1:0] {PWR_WAIT, INIT, REFRESH, IDLE} ctrl_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_SETUP, WR_EN, WR_WAIT} wr_state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_req_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_ON;
      2'd2:    return CLEAR;
      default: return ENTRY;
    endcase
  endfunction

  function automatic logic [7:0] line1_char(input usr_op_t op, input logic [31:0] crc,
                                            input logic [3:0] pos);
    int p;
    p = int'(pos);
    if (p < 4)       return CRC_TAG[8*(3-p) +: 8];
    else if (p < 12) return (op == OP_CRC) ? hex_ascii(crc[4*(11-p) +: 4]) : 8'h2D;
    else             return 8'h20;
  endfunction

  function automatic logic [7:0] line2_char(input logic ok, input logic [3:0] pos);
    logic [127:0] s;
    int p;
    p = int'(pos);
    s = ok ? STAT_OK : STAT_ERR;
    return s[8*(15-p) +: 8];
  endfunction

  function automatic int refresh_len(input usr_op_t op);
    case (op)
      OP_OFF:   return 1;
      OP_CLEAR: return 2;
      default:  return 35;
    endcase
  endfunction

  // Byte idx of a refresh burst: DISP_ON, LINE1, 16 chars, LINE2, 16 chars for text modes.
  function automatic lcd_req_t refresh_byte(input usr_op_t op, input logic [31:0] crc,
                                            input logic ok, input logic [5:0] idx);
    lcd_req_t r;
    int i;
    i = int'(idx);
    r = '{rs: 1'b0, data: DISP_ON};
    case (op)
      OP_OFF:   r.data = DISP_OFF;
      OP_CLEAR: if (i == 1) r.data = CLEAR;
      default: begin
        if (i == 1)                 r.data = LINE1;
        else if (i == 18)           r.data = LINE2;
        else if (i >= 2 && i <= 17) r = '{rs: 1'b1, data: line1_char(op, crc, 4'(i - 2))};
        else if (i >= 19)           r = '{rs: 1'b1, data: line2_char(ok, 4'(i - 19))};
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One HD44780 bus write: setup, enable strobe, post-write wait; done pulses in the last wait cycle.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int T_AS  = 2,
  parameter int T_EN  = 25,
  parameter int T_CMD = 2500,
  parameter int T_CLR = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  wr_state_t   st;
  logic [31:0] cnt;
  logic        long_l;

  // The start cycle that follows done is the final cycle of the previous wait,
  // so the wait phase itself runs one cycle short (T_CMD/T_CLR must be >= 2).
  assign done = (st == WR_WAIT) && (cnt == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      st       <= WR_IDLE;
      cnt      <= '0;
      long_l   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      case (st)
        WR_IDLE: if (start) begin
          lcd_rs   <= rs;
          lcd_data <= data;
          long_l   <= long_wait;
          cnt      <= 32'(T_AS - 1);
          st       <= WR_SETUP;
        end
        WR_SETUP: if (cnt == '0) begin
          lcd_en <= 1'b1;
          cnt    <= 32'(T_EN - 1);
          st     <= WR_EN;
        end else cnt <= cnt - 32'd1;
        WR_EN: if (cnt == '0) begin
          lcd_en <= 1'b0;
          cnt    <= long_l ? 32'(T_CLR - 2) : 32'(T_CMD - 2);
          st     <= WR_WAIT;
        end else cnt <= cnt - 32'd1;
        default: if (cnt == '0) st <= WR_IDLE;
                 else cnt <= cnt - 32'd1;
      endcase
    end
  end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// HD44780 sequencer: power-on wait, init commands, then two-line CRC/status refreshes on request.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWR = 1000000,
  parameter int T_AS  = 2,
  parameter int T_EN  = 25,
  parameter int T_CMD = 2500,
  parameter int T_CLR = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  usr_op,
  input  logic [31:0] crc,
  input  logic        crc_status,
  input  logic        update,
  output logic        busy,
  output logic [7:0]  lcd_data,
  output logic        lcd_en,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_backlight
);

  ctrl_state_t state;
  logic        pending;
  usr_op_t     op_l;
  logic [31:0] crc_l;
  logic        ok_l;
  logic [5:0]  idx;
  logic [31:0] pwr_cnt;
  logic        wr_start;
  lcd_req_t    wr_req;
  logic        wr_done;
  logic        wr_long;
  logic        take;
  usr_op_t     op_in;
  lcd_req_t    ref_first;
  lcd_req_t    ref_next;
  logic [5:0]  last_idx;

  assign op_in     = usr_op_t'(usr_op);
  assign ref_first = refresh_byte(op_in, crc, crc_status, 6'd0);
  assign ref_next  = refresh_byte(op_l, crc_l, ok_l, idx + 6'd1);
  assign last_idx  = 6'(refresh_len(op_l) - 1);
  assign wr_long   = !wr_req.rs && (wr_req.data == CLEAR || wr_req.data == HOME);

  // End of INIT behaves like an accepted request: inputs sampled that same cycle.
  assign take = (state == INIT && wr_done && idx == 6'd3) ||
                (state == IDLE && (update || pending));

  assign busy   = (state != IDLE) || pending;
  assign lcd_rw = 1'b0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= PWR_WAIT;
      pending       <= 1'b0;
      op_l          <= OP_CRC;
      crc_l         <= '0;
      ok_l          <= 1'b0;
      idx           <= '0;
      pwr_cnt       <= '0;
      wr_start      <= 1'b0;
      wr_req        <= '0;
      lcd_backlight <= 1'b1;
    end else begin
      wr_start <= 1'b0;
      if (state == IDLE && take)        pending <= 1'b0;
      else if (update && state != IDLE) pending <= 1'b1;

      if (take) begin
        op_l          <= op_in;
        crc_l         <= crc;
        ok_l          <= crc_status;
        lcd_backlight <= (op_in != OP_OFF);
        idx           <= '0;
        wr_start      <= 1'b1;
        wr_req        <= ref_first;
        state         <= REFRESH;
      end else begin
        case (state)
          PWR_WAIT: if (pwr_cnt == 32'(T_PWR - 1)) begin
            state    <= INIT;
            idx      <= '0;
            wr_start <= 1'b1;
            wr_req   <= '{rs: 1'b0, data: FUNC_SET};
          end else pwr_cnt <= pwr_cnt + 32'd1;
          INIT: if (wr_done) begin
            idx      <= idx + 6'd1;
            wr_start <= 1'b1;
            wr_req   <= '{rs: 1'b0, data: init_byte(idx[1:0] + 2'd1)};
          end
          REFRESH: if (wr_done) begin
            if (idx == last_idx) state <= IDLE;
            else begin
              idx      <= idx + 6'd1;
              wr_start <= 1'b1;
              wr_req   <= ref_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

  lcd_byte_writer #(
    .T_AS (T_AS),
    .T_EN (T_EN),
    .T_CMD(T_CMD),
    .T_CLR(T_CLR)
  ) u_writer (
    .clock    (clock),
    .reset    (reset),
    .start    (wr_start),
    .rs       (wr_req.rs),
    .data     (wr_req.data),
    .long_wait(wr_long),
    .done     (wr_done),
    .lcd_en   (lcd_en),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data)
  );

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Scoreboard bench: expected LCD byte stream built from display text, checked on each lcd_en strobe.
module tb_lcd_refresh_ctrl;
  localparam int T_PWR = 20, T_AS = 1, T_EN = 2, T_CMD = 3, T_CLR = 6;

  logic        clock = 1'b0, reset = 1'b0;
  logic [1:0]  usr_op = 2'd0;
  logic [31:0] crc = '0;
  logic        crc_status = 1'b0, update = 1'b0;
  logic        busy, lcd_en, lcd_rs, lcd_rw, lcd_backlight;
  logic [7:0]  lcd_data;

  int checks = 0, errors = 0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       bl;
    logic       long_w;
    logic       first;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clock = ~clock;

  lcd_refresh_ctrl #(.T_PWR(T_PWR), .T_AS(T_AS), .T_EN(T_EN), .T_CMD(T_CMD), .T_CLR(T_CLR)) dut (
    .clock(clock), .reset(reset), .usr_op(usr_op), .crc(crc), .crc_status(crc_status),
    .update(update), .busy(busy), .lcd_data(lcd_data), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_backlight(lcd_backlight)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_byte(input logic rs, input logic [7:0] d, input logic bl, input logic first);
    exp_t x;
    x.rs = rs; x.data = d; x.bl = bl; x.first = first;
    x.long_w = !rs && (d == 8'h01 || d == 8'h02);
    sb.push_back(x);
  endtask

  task automatic push_str(input string s, input logic bl);
    for (int i = 0; i < s.len(); i++) push_byte(1'b1, s[i], bl, 1'b0);
  endtask

  task automatic push_init();
    push_byte(0, 8'h38, 1, 1); push_byte(0, 8'h0C, 1, 0);
    push_byte(0, 8'h01, 1, 0); push_byte(0, 8'h06, 1, 0);
  endtask

  task automatic push_refresh(input logic [1:0] op, input logic [31:0] c, input logic s,
                              input logic first);
    string hx, l1;
    logic bl;
    int nib;
    hx = "0123456789ABCDEF";
    bl = (op != 2'd3);
    if (op == 2'd3) push_byte(0, 8'h08, bl, first);
    else if (op == 2'd2) begin
      push_byte(0, 8'h0C, bl, first); push_byte(0, 8'h01, bl, 0);
    end else begin
      if (op == 2'd0) begin
        l1 = "CRC:";
        for (int k = 7; k >= 0; k--) begin
          nib = int'(c[4*k +: 4]);
          l1 = {l1, hx.substr(nib, nib)};
        end
        l1 = {l1, "    "};
      end else l1 = "CRC:--------    ";
      push_byte(0, 8'h0C, bl, first); push_byte(0, 8'h80, bl, 0);
      push_str(l1, bl);
      push_byte(0, 8'hC0, bl, 0);
      push_str(s ? "STATUS: OK      " : "STATUS: ERROR   ", bl);
    end
  endtask

  // ---------------- monitor ----------------
  logic       prev_en = 1'b0, prev_busy = 1'b1, last_long = 1'b0, cap_rs = 1'b0;
  logic [7:0] cap_data = 8'h00;
  int         low_cnt = 0, high_cnt = 0;

  always @(negedge clock) begin
    if (!reset) begin
      prev_en = 1'b0; prev_busy = 1'b1; low_cnt = 0; high_cnt = 0; last_long = 1'b0;
    end else begin
      if (lcd_en && !prev_en) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got rs=%0b data=%02h, none expected", lcd_rs, lcd_data);
        end else begin
          e = sb.pop_front();
          chk("byte_rs", lcd_rs, e.rs);
          chk("byte_data", lcd_data, e.data);
          chk("backlight", lcd_backlight, e.bl);
          chk("rw", lcd_rw, 0);
          if (!e.first) chk("gap_cycles", low_cnt, (last_long ? T_CLR : T_CMD) + T_AS);
          last_long = e.long_w;
        end
        cap_rs = lcd_rs; cap_data = lcd_data; high_cnt = 0;
      end
      if (!lcd_en && prev_en) begin
        chk("en_width", high_cnt, T_EN);
        chk("hold_data", {lcd_rs, lcd_data}, {cap_rs, cap_data});
        low_cnt = 0;
      end
      if (lcd_en) high_cnt++; else low_cnt++;
      if (prev_busy && !busy) begin
        chk("busy_fall_wait", low_cnt, last_long ? T_CLR : T_CMD);
        chk("sb_drained", sb.size(), 0);
      end
      prev_en = lcd_en; prev_busy = busy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin @(negedge clock); n++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: still busy after %0d cycles", bound);
    end
    tick(1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_en", lcd_en, 0); chk("rst_rs", lcd_rs, 0); chk("rst_data", lcd_data, 0);
    chk("rst_rw", lcd_rw, 0); chk("rst_bl", lcd_backlight, 1); chk("rst_busy", busy, 1);
  endtask

  task automatic do_reset(input logic [1:0] op, input logic [31:0] c, input logic s);
    int n = 0;
    usr_op = op; crc = c; crc_status = s;
    reset = 1'b0;
    tick(3);
    check_reset_outputs();
    sb.delete();
    push_init();
    push_refresh(op, c, s, 0);
    reset = 1'b1;
    while (!lcd_en && n < T_PWR + 50) begin @(negedge clock); n++; end
    checks++;
    if (n < T_PWR + T_AS || n > T_PWR + T_AS + 2) begin
      errors++;
      $display("FAIL pwr_wait: first strobe after %0d cycles, expected %0d..%0d",
               n, T_PWR + T_AS, T_PWR + T_AS + 2);
    end
    wait_idle(3000);
  endtask

  task automatic request(input logic [1:0] op, input logic [31:0] c, input logic s);
    usr_op = op; crc = c; crc_status = s;
    chk("idle_before_req", busy, 0);
    push_refresh(op, c, s, 1);
    update = 1'b1;
    @(posedge clock); #1;
    chk("busy_rise", busy, 1);
    @(negedge clock);
    update = 1'b0;
  endtask

  initial begin
    logic [1:0]  op, op2;
    logic [31:0] c, c2;
    logic        s, s2;
    int          n;

    // 1: power-up, init and implicit refresh
    do_reset(2'd0, 32'hDEADBEEF, 1'b1);
    // 2: status-only mode with error
    request(2'd1, 32'h12345678, 1'b0);
    wait_idle(2000);
    // 3: display off, then clear
    request(2'd3, 32'h0, 1'b1);
    wait_idle(200);
    chk("bl_off", lcd_backlight, 0);
    request(2'd2, 32'h0, 1'b1);
    wait_idle(200);
    chk("bl_on", lcd_backlight, 1);
    // 4: coalesced requests during a refresh; inputs sampled when taken
    request(2'd0, 32'hCAFEF00D, 1'b1);
    tick(10);
    crc = 32'h00000001;
    push_refresh(2'd0, 32'h00000001, 1'b1, 1);
    repeat (3) begin update = 1'b1; tick(1); update = 1'b0; tick(2); end
    wait_idle(3000);
    // 5: reset while lcd_en is high mid-refresh
    request(2'd3, 32'h0, 1'b0);
    n = 0;
    while (!lcd_en && n < 50) begin @(negedge clock); n++; end
    chk("en_high_before_reset", lcd_en, 1);
    reset = 1'b0;
    @(posedge clock); #1;
    check_reset_outputs();
    do_reset(2'd0, 32'h0BADF00D, 1'b0);
    // 6: hex digit mapping
    request(2'd0, 32'hA5F00F5A, 1'b1);
    wait_idle(2000);

    // randomized requests, with occasional input churn or coalesced requests mid-refresh
    for (int it = 0; it < 16; it++) begin
      op = 2'($urandom_range(0, 3)); c = $urandom; s = 1'($urandom_range(0, 1));
      request(op, c, s);
      if (op < 2'd2) begin
        tick($urandom_range(1, 30));
        op2 = 2'($urandom_range(0, 3)); c2 = $urandom; s2 = 1'($urandom_range(0, 1));
        usr_op = op2; crc = c2; crc_status = s2;
        if ($urandom_range(0, 1) == 1) begin
          push_refresh(op2, c2, s2, 1);
          repeat ($urandom_range(1, 3)) begin
            update = 1'b1; tick(1); update = 1'b0; tick($urandom_range(0, 2));
          end
        end
      end
      wait_idle(3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/lcd_refresh_ctrl.md
Name: lcd_refresh_ctrl

Overview:
Sequencer that owns the HD44780 8-bit character LCD. After power-up it runs the controller init sequence. On each refresh request it rewrites both 16-character lines from the CRC result, the CRC status and the user display option. It sits between the processor-side config registers (usr_op, crc, crc_status, update) and the LCD pins, and drives every bus write with parameterised timing.

Parameters:
T_PWR, 1000000, power-on wait in clock cycles before the first command (20 ms at 50 MHz)
T_AS, 2, cycles rs/data are stable before lcd_en rises
T_EN, 25, cycles lcd_en is held high
T_CMD, 2500, cycles waited after lcd_en falls for normal commands and data (50 us)
T_CLR, 100000, cycles waited after lcd_en falls for clear (0x01) and home (0x02) (2 ms)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
usr_op  in  2  display mode: 00 CRC+status, 01 status only, 10 clear, 11 display and backlight off
crc  in  32  CRC value to show
crc_status  in  1  1 = CRC OK, 0 = error
update  in  1  one-cycle refresh request
busy  out  1  high while initialising, refreshing or while a request is pending
lcd_data  out  8  LCD data bus
lcd_en  out  1  LCD enable strobe
lcd_rs  out  1  0 = command, 1 = character data
lcd_rw  out  1  tied 0 (write only)
lcd_backlight  out  1  backlight enable

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to PWR_WAIT.
  - lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, lcd_backlight=1, busy=1.
  - Pending flag cleared, latched values cleared.
  - Reset asserted mid-write drops lcd_en on that edge; no partial sequence resumes.
- Write cycle, for every byte:
  - rs/data are driven for T_AS cycles.
  - lcd_en is high for T_EN cycles.
  - lcd_en is low and the block waits T_CMD cycles, or T_CLR if the byte is a command with value 0x01/0x02.
  - One byte occupies T_AS+T_EN+T_CMD cycles (or T_AS+T_EN+T_CLR).
  - rs/data stay stable until the next byte starts.
- State machine: PWR_WAIT → INIT → REFRESH → IDLE; REFRESH ↔ IDLE.
  - PWR_WAIT: counts T_PWR cycles, then enters INIT.
  - INIT: writes commands 0x38, 0x0C, 0x01, 0x06 in order, then enters REFRESH with an implicit request, using inputs sampled on the last INIT cycle.
  - IDLE: busy=0 unless pending. On update==1 or pending==1, latch usr_op, crc and crc_status, clear pending, and enter REFRESH on the next cycle.
  - REFRESH, by latched op:
    - 00/01: writes 0x0C, 0x80, 16 line-1 characters, 0xC0, 16 line-2 characters (35 writes).
    - 10: writes 0x0C, 0x01.
    - 11: writes 0x08.
    - Then returns to IDLE.
- Text, ASCII, exactly 16 characters per line:
  - op 00, line 1: "CRC:" + 8 uppercase hex digits of the latched crc, MSB nibble first, + 4 spaces.
  - op 01, line 1: "CRC:--------    ".
  - Line 2: "STATUS: OK      " if latched crc_status==1, else "STATUS: ERROR   ".
- lcd_backlight:
  - Set to 0 when a REFRESH with op 11 starts.
  - Set to 1 when a REFRESH with any other op starts.
  - Otherwise holds its value.
- update while busy (PWR_WAIT, INIT, REFRESH):
  - Sets pending; multiple requests coalesce into one.
  - Inputs are sampled when the pending request is taken in IDLE, not when update arrived.
  - An update on the same cycle IDLE is entered is accepted directly.
- Inputs changing during REFRESH have no effect on the current refresh.
- All counters are wide enough for the largest parameter; there is no wrap-around inside a wait.

Decomposition:
- Package lcd_pkg holds:
  - Command constants: FUNC_SET 0x38, DISP_ON 0x0C, DISP_OFF 0x08, CLEAR 0x01, ENTRY 0x06, LINE1 0x80, LINE2 0xC0.
  - usr_op encodings.
  - State enum.
  - Nibble-to-ASCII hex function.
- Sub-module lcd_byte_writer:
  - Inputs: start, rs, data, long_wait.
  - Outputs: done (one-cycle pulse), plus the pin drivers.
  - Implements the T_AS/T_EN/T_CMD/T_CLR timing.
- The top FSM handles only sequencing and character selection.

Test Plan:
1. Small params (T_PWR=20, T_AS=1, T_EN=2, T_CMD=3, T_CLR=6), crc=32'hDEADBEEF, status=1, op=00, release reset → INIT bytes 38,0C,01,06 (rs=0), then 0C,80,"CRC:DEADBEEF    ",C0,"STATUS: OK      "; lcd_en high exactly 2 cycles per byte; busy falls after the last wait.
2. In IDLE, set status=0, op=01, pulse update → line 1 "CRC:--------    ", line 2 "STATUS: ERROR   "; busy rises the cycle after update.
3. op=11 + update → single command 0x08, lcd_backlight=0; then op=10 + update → 0C, 01 with a 6-cycle post-wait on 01, lcd_backlight=1.
4. Three update pulses during a REFRESH, crc changed to 32'h00000001 after the first → exactly one further refresh, showing "CRC:00000001    ".
5. Assert reset mid-byte during REFRESH while lcd_en=1 → lcd_en=0 on the next edge, all outputs at reset values, full PWR_WAIT+INIT repeats.
6. crc=32'hA5F0_0F5A → hex digits "A5F00F5A", checking uppercase A–F and digit mapping at nibble boundaries.
